// File: rtl/neuron_pkg.sv
// Shared types and sizes for the single-neuron forward evaluator.
package neuron_pkg;
    localparam int N_DENDRITES = 32;
    localparam int WORD_W      = 32;
    localparam int ACC_W       = 70;

    typedef logic signed [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        FIN,
        DONE
    } neuron_state_t;
endpackage

// File: rtl/neuron_activate.sv
// Converts the wide accumulator to a saturated fixed-point word and applies ReLU.
module neuron_activate
    import neuron_pkg::*;
#(
    parameter int FRAC_BITS = 16
)
(
    input  logic signed [ACC_W-1:0]  i_acc,
    output logic        [WORD_W-1:0] o_preact,
    output logic        [WORD_W-1:0] o_axon,
    output logic                     o_fired
);

    // Saturate when the bits above the word's sign bit are not pure sign extension.
    function automatic logic [WORD_W-1:0] sat_word(input logic signed [ACC_W-1:0] v);
        logic [ACC_W-WORD_W:0] hi;
        hi = v[ACC_W-1:WORD_W-1];
        if ((&hi) || !(|hi))
            return v[WORD_W-1:0];
        else if (v[ACC_W-1])
            return {1'b1, {(WORD_W-1){1'b0}}};
        else
            return {1'b0, {(WORD_W-1){1'b1}}};
    endfunction

    logic signed [ACC_W-1:0] w_shift;

    assign w_shift  = i_acc >>> FRAC_BITS;
    assign o_preact = sat_word(w_shift);
    assign o_fired  = !o_preact[WORD_W-1] && (|o_preact);
    assign o_axon   = o_fired ? o_preact : '0;

endmodule

// File: rtl/neuron_forward_seq.sv
// Time-multiplexed forward pass of one 32-dendrite neuron: one multiplier,
// 70-bit accumulator, bias add and saturating ReLU, valid/ready on both sides.
module neuron_forward_seq
    import neuron_pkg::*;
#(
    parameter int FRAC_BITS = 16
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0][31:0] dendrites,
    input  logic [32:0][31:0] weights,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       axon,
    output logic [31:0]       preact,
    output logic              fired
);

    neuron_state_t           r_state;
    logic [4:0]              r_idx;
    logic signed [ACC_W-1:0] r_acc;
    word_t                   r_d [N_DENDRITES];
    word_t                   r_w [N_DENDRITES];
    word_t                   r_bias;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic [WORD_W-1:0]       r_axon;
    logic [WORD_W-1:0]       r_preact;
    logic                    r_fired;

    logic signed [63:0]      w_prod;
    logic signed [ACC_W-1:0] w_acc_fin;
    logic [WORD_W-1:0]       w_preact;
    logic [WORD_W-1:0]       w_axon;
    logic                    w_fired;

    assign w_prod    = 64'(r_d[r_idx]) * 64'(r_w[r_idx]);
    // Bias is a plain Q word, so align it with the Q(2*FRAC) products before adding.
    assign w_acc_fin = r_acc + (ACC_W'(r_bias) <<< FRAC_BITS);

    neuron_activate #(.FRAC_BITS(FRAC_BITS)) u_act (
        .i_acc    (w_acc_fin),
        .o_preact (w_preact),
        .o_axon   (w_axon),
        .o_fired  (w_fired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_acc       <= '0;
            r_bias      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_axon      <= '0;
            r_preact    <= '0;
            r_fired     <= 1'b0;
            for (int i = 0; i < N_DENDRITES; i++) begin
                r_d[i] <= '0;
                r_w[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < N_DENDRITES; i++) begin
                            r_d[i] <= dendrites[i];
                            r_w[i] <= weights[i];
                        end
                        r_bias     <= weights[32];
                        r_acc      <= '0;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= MAC;
                    end
                end
                MAC: begin
                    r_acc <= r_acc + ACC_W'(w_prod);
                    r_idx <= r_idx + 5'd1;
                    if (r_idx == 5'd31)
                        r_state <= FIN;
                end
                FIN: begin
                    r_acc       <= w_acc_fin;
                    r_preact    <= w_preact;
                    r_axon      <= w_axon;
                    r_fired     <= w_fired;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign axon      = r_axon;
    assign preact    = r_preact;
    assign fired     = r_fired;

endmodule

// File: tb/tb_neuron_forward_seq.sv
// Scoreboard bench for neuron_forward_seq: directed cases, backpressure,
// input churn after accept, mid-MAC reset and randomized operand sets.
module tb_neuron_forward_seq;

    typedef struct packed {
        logic [31:0] pre;
        logic [31:0] axn;
        logic        fir;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0][31:0] tb_d = '0;
    logic [32:0][31:0] tb_w = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [31:0]       axon;
    logic [31:0]       preact;
    logic              fired;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    neuron_forward_seq #(.FRAC_BITS(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dendrites (tb_d),
        .weights   (tb_w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .axon      (axon),
        .preact    (preact),
        .fired     (fired)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference: full-width sum, bias scaled by 2^16, signed clamp.
    function automatic exp_t model();
        logic signed [69:0] acc;
        logic signed [69:0] s;
        logic signed [69:0] hi;
        logic signed [69:0] lo;
        exp_t e;
        acc = '0;
        for (int i = 0; i < 32; i++)
            acc += 70'($signed(tb_d[i])) * 70'($signed(tb_w[i]));
        acc += 70'($signed(tb_w[32])) * 70'sd65536;
        s  = acc >>> 16;
        hi = 70'sd2147483647;
        lo = -hi - 70'sd1;
        if (s > hi)      e.pre = 32'h7FFFFFFF;
        else if (s < lo) e.pre = 32'h80000000;
        else             e.pre = s[31:0];
        e.fir = ($signed(e.pre) > 0);
        e.axn = e.fir ? e.pre : 32'h0;
        return e;
    endfunction

    task automatic scramble();
        for (int i = 0; i < 32; i++) tb_d[i] = $urandom;
        for (int i = 0; i < 33; i++) tb_w[i] = $urandom;
    endtask

    task automatic start_txn(input exp_t e);
        int n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        chk("accept_wait", 64'(n < 100), 64'd1);
        in_valid = 1'b1;
        sb_q.push_back(e);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int stall, input bit churn);
        int   cyc = 0;
        exp_t e;
        out_ready = (stall == 0);
        while (!out_valid && cyc < 100) begin
            if (churn) scramble();
            tick();
            cyc++;
        end
        chk("latency", 64'(cyc), 64'd33);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
            return;
        end
        e = sb_q.pop_front();
        chk("preact", 64'(preact), 64'(e.pre));
        chk("axon",   64'(axon),   64'(e.axn));
        chk("fired",  64'(fired),  64'(e.fir));
        for (int k = 0; k < stall; k++) begin
            in_valid = ~in_valid;
            scramble();
            tick();
            chk("stall_ov",  64'(out_valid), 64'd1);
            chk("stall_ir",  64'(in_ready),  64'd0);
            chk("stall_pre", 64'(preact),    64'(e.pre));
            chk("stall_axn", 64'(axon),      64'(e.axn));
            chk("stall_fir", 64'(fired),     64'(e.fir));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("rel_ov", 64'(out_valid), 64'd0);
        chk("rel_ir", 64'(in_ready),  64'd1);
    endtask

    task automatic set_all(input logic [31:0] d, input logic [31:0] w, input logic [31:0] b);
        for (int i = 0; i < 32; i++) begin
            tb_d[i] = d;
            tb_w[i] = w;
        end
        tb_w[32] = b;
    endtask

    initial begin
        exp_t e;
        int   seen;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_ov",  64'(out_valid), 64'd0);
        chk("rst_ir",  64'(in_ready),  64'd1);
        chk("rst_pre", 64'(preact),    64'd0);
        chk("rst_axn", 64'(axon),      64'd0);
        chk("rst_fir", 64'(fired),     64'd0);

        // 32 * 1.0 * 0.5 = 16.0
        set_all(32'h00010000, 32'h00008000, 32'h0);
        start_txn('{pre: 32'h00100000, axn: 32'h00100000, fir: 1'b1});
        wait_out(0, 1'b0);

        // 1.0 * -2.0 + 1.0 = -1.0
        set_all(32'h0, 32'h0, 32'h00010000);
        tb_d[0] = 32'h00010000;
        tb_w[0] = 32'hFFFE0000;
        start_txn('{pre: 32'hFFFF0000, axn: 32'h0, fir: 1'b0});
        wait_out(0, 1'b0);

        set_all(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
        start_txn('{pre: 32'h7FFFFFFF, axn: 32'h7FFFFFFF, fir: 1'b1});
        wait_out(0, 1'b0);

        set_all(32'h80000000, 32'h7FFFFFFF, 32'h0);
        start_txn('{pre: 32'h80000000, axn: 32'h0, fir: 1'b0});
        wait_out(10, 1'b0);

        // Accept immediately after the release cycle, then churn inputs.
        set_all(32'h00020000, 32'h00010000, 32'hFFFF8000);
        start_txn('{pre: 32'h003F8000, axn: 32'h003F8000, fir: 1'b1});
        wait_out(0, 1'b1);

        // Abort in MAC with a reset pulse.
        for (int i = 0; i < 32; i++) begin
            tb_d[i] = 32'($urandom_range(0, 32'h000FFFFF)) - 32'h00080000;
            tb_w[i] = 32'($urandom_range(0, 32'h000FFFFF)) - 32'h00080000;
        end
        tb_w[32] = 32'h00030000;
        e = model();
        start_txn(e);
        repeat (14) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(sb_q.pop_back());
        chk("abort_ov",  64'(out_valid), 64'd0);
        chk("abort_ir",  64'(in_ready),  64'd1);
        chk("abort_pre", 64'(preact),    64'd0);
        chk("abort_axn", 64'(axon),      64'd0);
        chk("abort_fir", 64'(fired),     64'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("abort_no_ov", 64'(seen), 64'd0);
        start_txn(e);
        wait_out(0, 1'b0);

        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 32; i++) begin
                tb_d[i] = 32'($urandom_range(0, 32'h000FFFFF)) - 32'h00080000;
                tb_w[i] = 32'($urandom_range(0, 32'h000FFFFF)) - 32'h00080000;
            end
            tb_w[32] = 32'($urandom_range(0, 32'h000FFFFF)) - 32'h00080000;
            start_txn(model());
            wait_out(t % 2 * 3, t[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
